// File: rtl/call_stack_pkg.sv
// Shared types and defaults for the subroutine call stack and its neighbours (control unit, PC).
package call_stack_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int PC_W_DEF   = 8;
  localparam int FLAG_W_DEF = 4;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [FLAG_W_DEF-1:0] flags;
  } stack_entry_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_SWAP = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_SWAP;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/call_stack_ram.sv
// Stack storage: DEPTH x W register file, one synchronous write port and one asynchronous read port.
module call_stack_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 12,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  // Contents are deliberately not reset; the pointer alone defines validity.
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware subroutine call stack: saves {return address, flags} on push and presents them on pop.
// Optional sticky overflow/underflow flags are built only when CALL_STACK_ERR_EN is defined.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int FLAG_W = FLAG_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_push_en,
  input  logic                       in_pop_en,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [FLAG_W-1:0]          in_flags,
  input  logic                       in_ret_enable_out,
  input  logic                       in_clear_err,
  output logic [PC_W-1:0]            out_ret_addr,
  output logic [FLAG_W-1:0]          out_stack_flags,
  output logic                       out_empty,
  output logic                       out_full,
  output logic [$clog2(DEPTH+1)-1:0] out_depth,
  output logic                       out_overflow,
  output logic                       out_underflow
);

  localparam int SP_W = $clog2(DEPTH+1);
  localparam int AW   = $clog2(DEPTH);
  localparam int EW   = PC_W + FLAG_W;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

  logic [SP_W-1:0] r_sp;
  logic [SP_W-1:0] w_sp_nxt;
  logic            w_empty;
  logic            w_full;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [AW-1:0]   w_raddr;
  logic [EW-1:0]   w_wdata;
  logic [EW-1:0]   w_rdata;
  logic [PC_W-1:0] w_top_pc;
  logic            w_ovf_set;
  logic            w_unf_set;
  stack_op_e       w_op;

  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == SP_FULL);
  assign w_op    = decode_op(in_push_en, in_pop_en);
  assign w_wdata = {in_pc, in_flags};
  assign w_raddr = AW'(r_sp - SP_ONE);

  // A simultaneous push+pop replaces the top in place; on an empty stack it degrades to a push.
  always_comb begin
    w_sp_nxt  = r_sp;
    w_we      = 1'b0;
    w_waddr   = AW'(r_sp);
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    case (w_op)
      OP_PUSH: begin
        if (w_full) begin
          w_ovf_set = 1'b1;
        end else begin
          w_we     = 1'b1;
          w_sp_nxt = r_sp + SP_ONE;
        end
      end
      OP_POP: begin
        if (w_empty) w_unf_set = 1'b1;
        else         w_sp_nxt  = r_sp - SP_ONE;
      end
      OP_SWAP: begin
        w_we = 1'b1;
        if (w_empty) begin
          w_unf_set = 1'b1;
          w_sp_nxt  = SP_ONE;
        end else begin
          w_waddr = AW'(r_sp - SP_ONE);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sp <= '0;
    else        r_sp <= w_sp_nxt;
  end

  call_stack_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Empty reads as zero so stale storage never leaks onto the bus or flags.
  assign w_top_pc        = w_empty ? '0 : w_rdata[EW-1:FLAG_W];
  assign out_stack_flags = w_empty ? '0 : w_rdata[FLAG_W-1:0];
  assign out_ret_addr    = in_ret_enable_out ? w_top_pc : {PC_W{1'bz}};

  assign out_empty = w_empty;
  assign out_full  = w_full;
  assign out_depth = r_sp;

`ifdef CALL_STACK_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)         r_overflow  <= 1'b1;
      else if (in_clear_err) r_overflow  <= 1'b0;
      if (w_unf_set)         r_underflow <= 1'b1;
      else if (in_clear_err) r_underflow <= 1'b0;
    end
  end

  assign out_overflow  = r_overflow;
  assign out_underflow = r_underflow;
`else
  logic w_unused_err;
  assign w_unused_err  = in_clear_err | w_ovf_set | w_unf_set;
  assign out_overflow  = 1'b0;
  assign out_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: a reference model feeds an expected-output scoreboard per cycle.
module tb_call_stack;

  localparam int DEPTH  = 8;
  localparam int PC_W   = 8;
  localparam int FLAG_W = 4;
`ifdef CALL_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [PC_W-1:0]   pc = '0;
  logic [FLAG_W-1:0] fl = '0;
  logic              ren = 1'b0;
  logic              clr = 1'b0;
  wire  [PC_W-1:0]   ret_addr;
  logic [FLAG_W-1:0] stk_flags;
  logic              empty, full, ovf, unf;
  logic [3:0]        depth;

  always #5 clk = ~clk;

  call_stack #(.DEPTH(DEPTH), .PC_W(PC_W), .FLAG_W(FLAG_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_push_en        (push),
    .in_pop_en         (pop),
    .in_pc             (pc),
    .in_flags          (fl),
    .in_ret_enable_out (ren),
    .in_clear_err      (clr),
    .out_ret_addr      (ret_addr),
    .out_stack_flags   (stk_flags),
    .out_empty         (empty),
    .out_full          (full),
    .out_depth         (depth),
    .out_overflow      (ovf),
    .out_underflow     (unf)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model
  logic [PC_W-1:0]   m_pc [DEPTH];
  logic [FLAG_W-1:0] m_fl [DEPTH];
  int                m_sp = 0;
  bit                m_ovf = 0;
  bit                m_unf = 0;

  typedef struct {
    int                depth;
    bit                empty;
    bit                full;
    logic [FLAG_W-1:0] fl;
    logic [PC_W-1:0]   pc;
    bit                ren;
    bit                ovf;
    bit                unf;
  } exp_t;

  exp_t sb[$];

  task automatic model_step(input bit p_push, input bit p_pop, input logic [PC_W-1:0] p_pc,
                            input logic [FLAG_W-1:0] p_fl, input bit p_clr);
    bit so = 0;
    bit su = 0;
    if (p_push && p_pop) begin
      if (m_sp == 0) begin
        m_pc[0] = p_pc; m_fl[0] = p_fl; m_sp = 1; su = 1;
      end else begin
        m_pc[m_sp-1] = p_pc; m_fl[m_sp-1] = p_fl;
      end
    end else if (p_push) begin
      if (m_sp == DEPTH) so = 1;
      else begin
        m_pc[m_sp] = p_pc; m_fl[m_sp] = p_fl; m_sp++;
      end
    end else if (p_pop) begin
      if (m_sp == 0) su = 1;
      else m_sp--;
    end
    if (so) m_ovf = 1; else if (p_clr) m_ovf = 0;
    if (su) m_unf = 1; else if (p_clr) m_unf = 0;
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("depth", 32'(depth), 32'(e.depth));
    chk("empty", 32'(empty), 32'(e.empty));
    chk("full", 32'(full), 32'(e.full));
    chk("stack_flags", 32'(stk_flags), 32'(e.fl));
    if (e.ren) chk("ret_addr", 32'(ret_addr), 32'(e.pc));
    chk("overflow", 32'(ovf), 32'(e.ovf));
    chk("underflow", 32'(unf), 32'(e.unf));
  endtask

  // One clock: drive at negedge, record expected pre-edge view, sample, then advance the model.
  task automatic cyc(input bit p_push, input bit p_pop, input logic [PC_W-1:0] p_pc,
                     input logic [FLAG_W-1:0] p_fl, input bit p_ren, input bit p_clr);
    exp_t e;
    @(negedge clk);
    push = p_push; pop = p_pop; pc = p_pc; fl = p_fl; ren = p_ren; clr = p_clr;
    e.depth = m_sp;
    e.empty = (m_sp == 0);
    e.full  = (m_sp == DEPTH);
    e.fl    = (m_sp == 0) ? '0 : m_fl[m_sp-1];
    e.pc    = (m_sp == 0) ? '0 : m_pc[m_sp-1];
    e.ren   = p_ren;
    e.ovf   = ERR_EN & m_ovf;
    e.unf   = ERR_EN & m_unf;
    sb.push_back(e);
    #2;
    check_sb();
    @(posedge clk);
    model_step(p_push, p_pop, p_pc, p_fl, p_clr);
  endtask

  task automatic idle(input bit p_ren);
    cyc(0, 0, 8'h00, 4'h0, p_ren, 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_flags", 32'(stk_flags), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single push, visible next cycle
    cyc(1, 0, 8'h12, 4'h1, 1, 0);
    idle(1);
    cyc(0, 1, 8'h00, 4'h0, 1, 0);

    // Three pushes then three pops with zero-latency data
    cyc(1, 0, 8'h10, 4'h2, 0, 0);
    cyc(1, 0, 8'h20, 4'h3, 0, 0);
    cyc(1, 0, 8'h30, 4'h4, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h00, 4'h0, 1, 0);
    idle(1);

    // Fill, overflow, clear, and set-beats-clear
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'(8'h80 + i), 4'(i), 0, 0);
    cyc(1, 0, 8'hFF, 4'hF, 1, 0);
    idle(1);
    cyc(0, 0, 8'h00, 4'h0, 1, 1);
    idle(1);
    cyc(1, 0, 8'hEE, 4'hE, 1, 1);
    idle(1);
    cyc(0, 0, 8'h00, 4'h0, 0, 1);

    // Drain, then underflow on empty
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 8'h00, 4'h0, 1, 0);
    cyc(0, 1, 8'h00, 4'h0, 1, 0);
    idle(1);
    cyc(0, 0, 8'h00, 4'h0, 0, 1);

    // Replace-top on non-empty, then push+pop on empty
    cyc(1, 0, 8'h40, 4'h4, 0, 0);
    cyc(1, 1, 8'h55, 4'h5, 1, 0);
    idle(1);
    cyc(0, 1, 8'h00, 4'h0, 1, 0);
    cyc(1, 1, 8'h66, 4'h6, 1, 0);
    idle(1);
    cyc(0, 1, 8'h00, 4'h0, 1, 1);

    // Back-to-back random traffic
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    idle(1);

    // Async reset mid-cycle empties immediately; a later pop underflows
    cyc(0, 0, 8'h00, 4'h0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 8'h00, 4'h0, 0, 1);
    cyc(1, 0, 8'hA1, 4'h1, 0, 0);
    cyc(1, 0, 8'hA2, 4'h2, 0, 0);
    @(negedge clk);
    push = 0; pop = 0; ren = 0; clr = 0;
    #2;
    chk("pre_rst_depth", 32'(depth), 32'(m_sp));
    rst_n = 1'b0;
    #1;
    chk("midrst_depth", 32'(depth), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_flags", 32'(stk_flags), 32'd0);
    m_sp = 0; m_ovf = 0; m_unf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 8'h00, 4'h0, 0, 0);
    idle(1);
    idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/call_stack.md
# call_stack

Hardware subroutine stack that responds to the control unit's push/pop strobes. On a call it saves the return address and the current 4-bit flags; on a return it presents the saved return address and flags so the control unit and PC can restore them. It sits between the control unit (push/pop enables in, stack flags out) and the PC / internal data bus (return address out).

## Interface
Parameters:
- DEPTH, 8: number of entries; power of two, at least 2.
- PC_W, 8: return-address width.
- FLAG_W, 4: saved-flags width.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_push_en, input, 1: push request, one cycle per push (from control unit push_stack).
- in_pop_en, input, 1: pop request, one cycle per pop (from control unit pop_stack).
- in_pc, input, PC_W: return address to save (PC after increment).
- in_flags, input, FLAG_W: flags to save (control unit flag register).
- in_ret_enable_out, input, 1: drive the return address onto the bus.
- in_clear_err, input, 1: clear the sticky error bits.
- out_ret_addr, output, PC_W: top-of-stack return address. High-Z unless in_ret_enable_out is high.
- out_stack_flags, output, FLAG_W: top-of-stack flags (feeds control unit in_stack_flags).
- out_empty, output, 1: depth == 0.
- out_full, output, 1: depth == DEPTH.
- out_depth, output, $clog2(DEPTH+1): current entry count.
- out_overflow, output, 1: sticky; set by a push while full.
- out_underflow, output, 1: sticky; set by a pop while empty.

## Operation
- State:
  - Stack pointer `sp`, which equals depth.
  - Storage array of DEPTH entries `{pc, flags}`.
  - Top of stack is entry sp-1.
- Top-of-stack outputs are combinational from entry sp-1. While empty, out_ret_addr (when enabled) and out_stack_flags read 0.
- Push only, not full: write `{in_pc, in_flags}` to entry sp; then sp ← sp+1.
- Push only, full: storage and sp unchanged; out_overflow ← 1.
- Pop only, not empty: sp ← sp−1. The entry contents are left in place (not cleared).
- Pop only, empty: sp unchanged; out_underflow ← 1.
- Push and pop in the same cycle, not empty: overwrite entry sp-1 with `{in_pc, in_flags}`; sp unchanged. Outputs in that cycle show the old top.
- Push and pop in the same cycle, empty: perform the push (sp ← 1) and set out_underflow.
- in_clear_err clears both sticky bits. If a new error occurs in the same cycle, the set wins.
- Reset: sp = 0; out_overflow = out_underflow = 0; out_empty = 1; out_full = 0; out_depth = 0; out_stack_flags = 0; out_ret_addr = Z. Storage contents are not reset.

## Timing
- Push latency: the entry is visible on the top-of-stack outputs the cycle after the push strobe.
- Pop is zero-latency for data. During the cycle in which in_pop_en is high, out_stack_flags and out_ret_addr already show the entry being popped. The control unit captures flags on that same edge; sp decrements on that edge.
- A return sequence needs in_ret_enable_out (with the PC load) asserted in the pop cycle or in a cycle before it. After the pop edge the outputs show the next entry.
- Back-to-back pushes and pops every cycle are supported, with no bubbles.
- An asynchronous reset in the middle of a call or return sequence immediately empties the stack. A pop strobe that arrives after reset sets out_underflow.
- out_empty, out_full and out_depth are derived from the registered sp; there is no combinational path from the strobes to these outputs.

## Configuration
- CALL_STACK_ERR_EN:
  - Defined: out_overflow and out_underflow are implemented as sticky registers, and in_clear_err is honoured.
  - Undefined: both outputs are tied to 0 and in_clear_err is ignored. Illegal pushes and pops are still ignored; sp never wraps in either build.

## Structure
- Shared package: PC_W and FLAG_W defaults, plus a stack-entry typedef `{pc, flags}` for common use by the control unit and PC.
- Sub-module `call_stack_ram`: DEPTH × (PC_W+FLAG_W) register file, one synchronous write port and one asynchronous read port addressed by sp-1.
- Pointer logic, full/empty logic, error logic and the tri-state bus driver stay in `call_stack`.

## Test plan
- Reset, then push pc=0x12 with flags=0x1 → next cycle depth=1 and out_stack_flags=0x1; with enable high, out_ret_addr=0x12.
- Push 0x10, 0x20, 0x30, then pop three times → during each pop cycle out_ret_addr reads 0x30, 0x20, 0x10; empty=1 at the end.
- Push DEPTH entries, then push 0xFF → full=1, depth=DEPTH, overflow=1, top entry unchanged; pulse in_clear_err → overflow=0.
- Pop while empty → underflow=1, depth=0, out_stack_flags=0.
- Push 0x40, then push 0x55 and pop in the same cycle → depth stays 1 and the top reads 0x55.
- Push two entries, then drop rst_n mid-cycle → depth=0 and empty=1 immediately, before the next clock edge.
